store_word_serializer: RTL and testbench
========================================

// Module: store_word_serializer
// PURPOSE
//  Write-side counterpart of the byte-wise instruction fetch path: accepts one
//  32-bit word plus base address and writes it into byte-wide memory as four
//  sequential byte writes, MSB first (bits 31:24 -> base, 7:0 -> base+3).
//  Sits between the multicycle controller's store path and the 8-bit memory port.
// PARAMETERS
//  ADDR_WIDTH  8  width of byte address; address arithmetic wraps modulo 2**ADDR_WIDTH
// PORTS
//  ph1         in   1           clock; all state updates on posedge ph1
//  reset       in   1           asynchronous, active-high reset
//  StoreValid  in   1           store request valid
//  StoreReady  out  1           block can accept a request (IDLE only)
//  StoreAddr   in   ADDR_WIDTH  byte address of MSB
//  StoreData   in   32          word to store
//  MemBusy     in   1           memory stall; current byte write held while high
//  MemWrite    out  1           byte write strobe (registered)
//  MemAdr      out  ADDR_WIDTH  byte write address (registered)
//  WriteData   out  8           byte write data (registered)
//  StoreDone   out  1           one-cycle pulse after final byte accepted
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; StoreReady=1, MemWrite=0, MemAdr=0,
//    WriteData=0, StoreDone=0; captured data/address cleared.
//  - States: IDLE -> WR0 -> WR1 -> WR2 -> WR3 -> IDLE. StoreReady = (state==IDLE).
//  - Accept: StoreValid && StoreReady at posedge -> capture StoreAddr/StoreData,
//    enter WR0. StoreValid outside IDLE ignored; captured values not disturbed.
//  - In WRn: MemWrite=1, MemAdr=base+n (wraps), WriteData=byte n (n=0 is 31:24).
//  - MemBusy=1 at posedge in WRn: stay in WRn, outputs unchanged. MemBusy=0:
//    byte n complete, advance. MemBusy ignored in IDLE.
//  - After WR3 completes: IDLE, MemWrite=0, StoreDone=1 for exactly one cycle.
//  - Latency (MemBusy=0): accept at edge k; bytes visible k..k+3 edges; StoreDone
//    high between edges k+4 and k+5. Each MemBusy stall cycle adds one cycle.
//  - Back-to-back: a request presented while StoreDone=1 is accepted (IDLE);
//    peak throughput one word per 5 cycles.
//  - Reset mid-operation: store abandoned, bytes already written stay written,
//    no StoreDone pulse.
//  - Outputs MemAdr/WriteData hold last values in IDLE (only MemWrite qualifies).
// CONFIGURATION
//  STORE_BYTE_MASK_EN defined: adds input ByteEn[3:0] (bit 3 = byte 0/MSB),
//   captured at accept. Bytes with ByteEn bit 0 are skipped: no write, no cycle;
//   addresses of written bytes remain base+n. ByteEn=0000: no writes, StoreDone
//   pulses the cycle after acceptance.
//  Not defined: no ByteEn port; all four bytes always written.
// TESTING
//  1. Reset, store 0xDEADBEEF @0x10, MemBusy=0 -> DE@10, AD@11, BE@12, EF@13 on
//     4 consecutive cycles, then StoreDone one cycle, StoreReady=1.
//  2. Store 0x01020304 @0xFE -> 01@FE, 02@FF, 03@00, 04@01 (wrap).
//  3. MemBusy=1 for 2 cycles in WR1 -> 0xAD@0x11 held 3 cycles, StoreDone 2
//     cycles later than test 1.
//  4. StoreValid with 0x11111111 during WR2 -> ignored, original bytes complete;
//     new request in StoreDone cycle -> accepted, WR0 next cycle.
//  5. Assert reset during WR2 (between edges) -> MemWrite=0, StoreReady=1
//     immediately; no StoreDone after release.
//  6. STORE_BYTE_MASK_EN, ByteEn=1010, 0xDEADBEEF @0x20 -> DE@20, BE@22 in 2
//     cycles then StoreDone; ByteEn=0000 -> no MemWrite, StoreDone next cycle.

Source files
------------

// File: rtl/store_word_serializer_if.sv
// rtl/store_word_serializer_if.sv - store request and byte-memory port bundle (ByteEn present with STORE_BYTE_MASK_EN)
interface store_word_serializer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  StoreValid;
  logic                  StoreReady;
  logic [ADDR_WIDTH-1:0] StoreAddr;
  logic [31:0]           StoreData;
`ifdef STORE_BYTE_MASK_EN
  logic [3:0]            ByteEn;
`endif
  logic                  MemBusy;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] MemAdr;
  logic [7:0]            WriteData;
  logic                  StoreDone;

  // Requester and memory side: drives requests and stalls, observes byte writes.
  modport master (
    output StoreValid, StoreAddr, StoreData, MemBusy,
`ifdef STORE_BYTE_MASK_EN
    output ByteEn,
`endif
    input  StoreReady, MemWrite, MemAdr, WriteData, StoreDone
  );

  // Serializer side.
  modport slave (
    input  StoreValid, StoreAddr, StoreData, MemBusy,
`ifdef STORE_BYTE_MASK_EN
    input  ByteEn,
`endif
    output StoreReady, MemWrite, MemAdr, WriteData, StoreDone
  );
endinterface

// File: rtl/store_word_serializer.sv
// rtl/store_word_serializer.sv - splits a 32-bit store into four MSB-first byte writes (optional byte mask via STORE_BYTE_MASK_EN)
module store_word_serializer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  ph1,
  input  logic                  reset,
  store_word_serializer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q, base_sel;
  logic [31:0]           data_q, data_sel;
  logic [3:0]            mask_in, mask_cur, mask_sel;
  logic                  accept, advance;
  logic [1:0]            cur_idx;
  logic [2:0]            nxt_idx;
  logic                  mem_write_q, mem_write_nxt;
  logic [ADDR_WIDTH-1:0] mem_adr_q, mem_adr_nxt;
  logic [7:0]            write_data_q, write_data_nxt;
  logic                  store_done_q, store_done_nxt;

  // First enabled byte index at or after start; 4 means no byte remains.
  // Mask bit 3 belongs to byte 0 (the MSB).
  function automatic logic [2:0] first_enabled(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    if (start == 3'd0 && mask[3])                           r = 3'd0;
    else if ((start == 3'd0 || start == 3'd1) && mask[2])   r = 3'd1;
    else if (start != 3'd3 && start != 3'd4 && mask[1])     r = 3'd2;
    else if (start != 3'd4 && mask[0])                      r = 3'd3;
    else                                                    r = 3'd4;
    return r;
  endfunction

  // Byte n of a word, n = 0 being bits 31:24.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n);
    logic [7:0] b;
    case (n)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

`ifdef STORE_BYTE_MASK_EN
  logic [3:0] mask_q;
  assign mask_in  = bus.ByteEn;
  assign mask_cur = mask_q;

  // Byte mask captured together with the request.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset)       mask_q <= 4'h0;
    else if (accept) mask_q <= mask_in;
  end
`else
  assign mask_in  = 4'hF;
  assign mask_cur = 4'hF;
`endif

  // State register.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, request capture selection and next registered outputs.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    advance        = 1'b0;
    base_sel       = base_q;
    data_sel       = data_q;
    mask_sel       = mask_cur;
    nxt_idx        = 3'd4;
    cur_idx        = 2'd0;
    case (state)
      WR0:     cur_idx = 2'd0;
      WR1:     cur_idx = 2'd1;
      WR2:     cur_idx = 2'd2;
      WR3:     cur_idx = 2'd3;
      default: cur_idx = 2'd0;
    endcase

    if (state == IDLE) begin
      if (bus.StoreValid) begin
        accept   = 1'b1;
        advance  = 1'b1;
        base_sel = bus.StoreAddr;
        data_sel = bus.StoreData;
        mask_sel = mask_in;
        nxt_idx  = first_enabled(mask_in, 3'd0);
      end
    end else if (!bus.MemBusy) begin
      advance = 1'b1;
      nxt_idx = first_enabled(mask_cur, {1'b0, cur_idx} + 3'd1);
    end

    if (advance) begin
      case (nxt_idx)
        3'd0:    state_nxt = WR0;
        3'd1:    state_nxt = WR1;
        3'd2:    state_nxt = WR2;
        3'd3:    state_nxt = WR3;
        default: state_nxt = IDLE;
      endcase
    end

    // A stalled byte keeps its outputs; idle keeps address/data, only the strobe drops.
    mem_write_nxt  = (state_nxt != IDLE);
    store_done_nxt = advance && nxt_idx[2] && !reset;
    mem_adr_nxt    = mem_adr_q;
    write_data_nxt = write_data_q;
    if (advance && !nxt_idx[2]) begin
      mem_adr_nxt    = base_sel + ADDR_WIDTH'(nxt_idx[1:0]);
      write_data_nxt = word_byte(data_sel, nxt_idx[1:0]);
    end
  end

  // Captured request; untouched outside an accept.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      base_q <= base_sel;
      data_q <= data_sel;
    end
  end

  // Registered memory-port outputs and completion pulse.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      mem_write_q  <= 1'b0;
      mem_adr_q    <= '0;
      write_data_q <= 8'h00;
      store_done_q <= 1'b0;
    end else begin
      mem_write_q  <= mem_write_nxt;
      mem_adr_q    <= mem_adr_nxt;
      write_data_q <= write_data_nxt;
      store_done_q <= store_done_nxt;
    end
  end

  assign bus.StoreReady = (state == IDLE);
  assign bus.MemWrite   = mem_write_q;
  assign bus.MemAdr     = mem_adr_q;
  assign bus.WriteData  = write_data_q;
  assign bus.StoreDone  = store_done_q;

  // mask_sel mirrors the mask being followed; kept for symmetry with base/data selection.
  logic unused_mask;
  assign unused_mask = ^mask_sel;

endmodule

// File: tb/tb_store_word_serializer.sv
// tb/tb_store_word_serializer.sv - randomized self-checking bench for store_word_serializer (STORE_BYTE_MASK_EN aware)
module tb_store_word_serializer;

  logic ph1;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [7:0] last_adr;
  logic [7:0] last_wd;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  store_word_serializer_if #(.ADDR_WIDTH(8)) bus ();

  store_word_serializer #(.ADDR_WIDTH(8)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.StoreValid = 1'b0;
      bus.MemBusy    = 1'($urandom % 2);
      @(posedge ph1); @(negedge ph1);
      chk("idle_write", {31'b0, bus.MemWrite}, 32'd0);
      chk("idle_done",  {31'b0, bus.StoreDone}, 32'd0);
      chk("idle_ready", {31'b0, bus.StoreReady}, 32'd1);
      chk("idle_adr_hold", {24'b0, bus.MemAdr}, {24'b0, last_adr});
      chk("idle_wd_hold",  {24'b0, bus.WriteData}, {24'b0, last_wd});
    end
  endtask

  // Called just after a falling edge with the block idle. Returns at the falling
  // edge where StoreDone is expected, so a following call presents back-to-back.
  // busy_pct = 0 uses busy_seq bit i as MemBusy for write cycle i.
  task automatic do_store(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [31:0] busy_seq, input int busy_pct);
    wr_t        q[$];
    wr_t        e;
    logic [3:0] eff;
    logic       busy;
    int         cyc;
`ifdef STORE_BYTE_MASK_EN
    eff = m;
    bus.ByteEn = m;
`else
    eff = 4'hF;
`endif
    for (int n = 0; n < 4; n++) begin
      if (eff[3-n]) begin
        e.a = 8'(a + 8'(n));
        e.d = 8'(d >> (24 - 8 * n));
        q.push_back(e);
      end
    end
    chk("accept_ready", {31'b0, bus.StoreReady}, 32'd1);
    bus.StoreValid = 1'b1;
    bus.StoreAddr  = a;
    bus.StoreData  = d;
    bus.MemBusy    = 1'($urandom % 2);
    @(posedge ph1); @(negedge ph1);
    cyc = 0;
    while (1) begin
      if (q.size() == 0) begin
        chk("done_write", {31'b0, bus.MemWrite}, 32'd0);
        chk("done_pulse", {31'b0, bus.StoreDone}, 32'd1);
        chk("done_ready", {31'b0, bus.StoreReady}, 32'd1);
        chk("done_adr_hold", {24'b0, bus.MemAdr}, {24'b0, last_adr});
        chk("done_wd_hold",  {24'b0, bus.WriteData}, {24'b0, last_wd});
        bus.StoreValid = 1'b0;
        break;
      end
      chk("wr_strobe", {31'b0, bus.MemWrite}, 32'd1);
      chk("wr_adr",  {24'b0, bus.MemAdr}, {24'b0, q[0].a});
      chk("wr_data", {24'b0, bus.WriteData}, {24'b0, q[0].d});
      chk("wr_done_low", {31'b0, bus.StoreDone}, 32'd0);
      chk("wr_ready_low", {31'b0, bus.StoreReady}, 32'd0);
      // Requests while busy writing must be ignored.
      bus.StoreValid = 1'($urandom % 2);
      bus.StoreAddr  = 8'($urandom);
      bus.StoreData  = $urandom;
`ifdef STORE_BYTE_MASK_EN
      bus.ByteEn     = 4'($urandom);
`endif
      if (busy_pct == 0) busy = (cyc < 32) ? busy_seq[cyc] : 1'b0;
      else               busy = ($urandom_range(0, 99) < busy_pct);
      bus.MemBusy = busy;
      @(posedge ph1); @(negedge ph1);
      if (!busy) begin
        last_adr = q[0].a;
        last_wd  = q[0].d;
        void'(q.pop_front());
      end
      cyc++;
      if (cyc > 200) begin
        vectors++;
        miscompares++;
        $error("FAIL store_timeout observed=%0d cycles expected=completion", cyc);
        bus.StoreValid = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.StoreValid = 1'b0;
    bus.StoreAddr  = 8'h00;
    bus.StoreData  = 32'h0;
    bus.MemBusy    = 1'b0;
`ifdef STORE_BYTE_MASK_EN
    bus.ByteEn     = 4'hF;
`endif
    #1;
    chk("rst_ready", {31'b0, bus.StoreReady}, 32'd1);
    chk("rst_write", {31'b0, bus.MemWrite}, 32'd0);
    chk("rst_adr",   {24'b0, bus.MemAdr}, 32'd0);
    chk("rst_wd",    {24'b0, bus.WriteData}, 32'd0);
    chk("rst_done",  {31'b0, bus.StoreDone}, 32'd0);
    @(negedge ph1);
    reset    = 1'b0;
    last_adr = 8'h00;
    last_wd  = 8'h00;
    idle(2);

    // Basic store, then address wrap.
    do_store(8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    idle(1);
    do_store(8'hFE, 32'h01020304, 4'hF, 32'h0, 0);
    idle(1);
    // Two stall cycles on the second byte.
    do_store(8'h10, 32'hDEADBEEF, 4'hF, 32'b0110, 0);
    // Back-to-back requests in the StoreDone cycle.
    do_store(8'h80, 32'hA5C3_0F96, 4'hF, 32'h0, 0);
    do_store(8'h84, 32'h1234_5678, 4'hF, 32'b1, 0);
    idle(1);

    // Reset while the third byte is on the bus.
    bus.StoreValid = 1'b1;
    bus.StoreAddr  = 8'h40;
    bus.StoreData  = 32'hCAFEF00D;
    bus.MemBusy    = 1'b0;
`ifdef STORE_BYTE_MASK_EN
    bus.ByteEn     = 4'hF;
`endif
    @(posedge ph1); @(negedge ph1);
    bus.StoreValid = 1'b0;
    chk("rstmid_b0", {bus.MemAdr, bus.WriteData}, {16'b0, 8'h40, 8'hCA});
    @(posedge ph1); @(negedge ph1);
    chk("rstmid_b1", {bus.MemAdr, bus.WriteData}, {16'b0, 8'h41, 8'hFE});
    @(posedge ph1); @(negedge ph1);
    chk("rstmid_b2", {bus.MemAdr, bus.WriteData}, {16'b0, 8'h42, 8'hF0});
    #2 reset = 1'b1;
    #1;
    chk("rstmid_write", {31'b0, bus.MemWrite}, 32'd0);
    chk("rstmid_ready", {31'b0, bus.StoreReady}, 32'd1);
    chk("rstmid_done",  {31'b0, bus.StoreDone}, 32'd0);
    @(negedge ph1);
    reset    = 1'b0;
    last_adr = 8'h00;
    last_wd  = 8'h00;
    idle(3);

`ifdef STORE_BYTE_MASK_EN
    do_store(8'h20, 32'hDEADBEEF, 4'b1010, 32'h0, 0);
    idle(1);
    do_store(8'h30, 32'h55AA55AA, 4'b0000, 32'h0, 0);
    idle(1);
    do_store(8'hFF, 32'h0BADF00D, 4'b0101, 32'b10, 0);
    idle(1);
`endif

    // Randomized stores with random stalls, gaps and masks.
    for (int i = 0; i < 40; i++) begin
      do_store(8'($urandom), $urandom, 4'($urandom), 32'h0, 30);
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
